// File: rtl/hough_pkg.sv
// Shared types and trig-table helpers for the Hough rho generator.
// Table entries are round(f * 2^frac), built at elaboration time.
package hough_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int TRIG_FRAC = 10;
    localparam int TRIG_Q    = 30;
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int trig_width(input int frac);
        return frac + 2;
    endfunction

    localparam int TRIG_W = trig_width(TRIG_FRAC);

    // Taylor series of sin for 0..90 degrees in Q30
    function automatic longint sin_fix(input int deg);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (longint'(deg) * PI_Q30) / 180;
        x2   = (x * x) >>> TRIG_Q;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> TRIG_Q) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic longint sin_deg(input int d);
        if (d <= 90)
            return sin_fix(d);
        else if (d <= 180)
            return sin_fix(180 - d);
        else if (d <= 270)
            return -sin_fix(d - 180);
        else
            return -sin_fix(360 - d);
    endfunction

    function automatic int trig_entry(input int deg, input bit is_cos, input int frac);
        int     d;
        longint m;
        longint mag;
        longint r;
        d   = is_cos ? (deg + 90) % 360 : deg % 360;
        m   = sin_deg(d);
        mag = (m < 0) ? -m : m;
        r   = (mag + (64'sd1 <<< (TRIG_Q - 1 - frac))) >>> (TRIG_Q - frac);
        return int'((m < 0) ? -r : r);
    endfunction

endpackage

// File: rtl/hough_trig_rom.sv
// Registered cos/sin ROM returning LANES consecutive angles per group.
// Contents are generated from rounded constants at elaboration.
module hough_trig_rom #(
    parameter int THETAS    = 180,
    parameter int LANES     = 4,
    parameter int TRIG_FRAC = 10,
    parameter int TW        = TRIG_FRAC + 2,
    parameter int GW        = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [GW-1:0]         grp,
    output logic [LANES*TW-1:0]   cos_q,
    output logic [LANES*TW-1:0]   sin_q
);
    import hough_pkg::*;

    localparam int AW = (THETAS > 1) ? $clog2(THETAS) : 1;

    logic signed [TW-1:0] cos_tab [THETAS];
    logic signed [TW-1:0] sin_tab [THETAS];

    for (genvar a = 0; a < THETAS; a++) begin : g_tab
        localparam logic signed [TW-1:0] C = TW'(trig_entry(a, 1'b1, TRIG_FRAC));
        localparam logic signed [TW-1:0] S = TW'(trig_entry(a, 1'b0, TRIG_FRAC));
        assign cos_tab[a] = C;
        assign sin_tab[a] = S;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cos_q <= '0;
            sin_q <= '0;
        end else if (en) begin
            for (int k = 0; k < LANES; k++) begin
                cos_q[k*TW +: TW] <= cos_tab[AW'(int'(grp) * LANES + k)];
                sin_q[k*TW +: TW] <= sin_tab[AW'(int'(grp) * LANES + k)];
            end
        end
    end

endmodule

// File: rtl/hough_rho_gen.sv
// Multi-lane Hough rho generator: pixel in, LANES rho bins per cycle out.
// Define HOUGH_RHO_CLAMP_EN to saturate out-of-range bins instead of masking.
module hough_rho_gen #(
    parameter int THETAS     = 180,
    parameter int LANES      = 4,
    parameter int IMG_BITS   = 10,
    parameter int TRIG_FRAC  = hough_pkg::TRIG_FRAC,
    parameter int RHO_SHIFT  = 0,
    parameter int RHOS       = 2048,
    parameter int RHO_BITS   = 11,
    parameter int THETA_BITS = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pix_empty,
    output logic                        pix_rd_en,
    input  logic [IMG_BITS-1:0]         pix_x,
    input  logic [IMG_BITS-1:0]         pix_y,
    input  logic                        rho_full,
    output logic                        rho_wr_en,
    output logic [LANES*RHO_BITS-1:0]   rho_dout,
    output logic [THETA_BITS-1:0]       rho_theta,
    output logic [LANES-1:0]            rho_valid,
    output logic                        rho_last
);
    import hough_pkg::*;

    localparam int GROUPS = THETAS / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int TW     = trig_width(TRIG_FRAC);
    localparam int PW     = IMG_BITS + 1 + TW;
    localparam int SW     = 2 * IMG_BITS + TRIG_FRAC + 4;
    localparam int SH     = TRIG_FRAC + RHO_SHIFT;

    state_t                state, state_n;
    logic [GW-1:0]         grp, grp_n;
    logic [IMG_BITS-1:0]   px, py;
    logic                  adv;
    logic                  iss;

    logic [LANES*TW-1:0]   cos_q, sin_q;
    logic                  s1_valid, s1_last;
    logic [THETA_BITS-1:0] s1_theta;
    logic [IMG_BITS-1:0]   s1_x, s1_y;

    logic                  s2_valid, s2_last;
    logic [THETA_BITS-1:0] s2_theta;
    logic signed [PW-1:0]  s2_xc [LANES];
    logic signed [PW-1:0]  s2_ys [LANES];

    logic                  s3_valid;
    logic [LANES*RHO_BITS-1:0] d_n;
    logic [LANES-1:0]      v_n;

    assign adv       = !(s3_valid && rho_full);
    assign rho_wr_en = s3_valid && !rho_full;

    always_comb begin
        state_n   = state;
        grp_n     = grp;
        pix_rd_en = 1'b0;
        iss       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!pix_empty && !reset) begin
                    pix_rd_en = 1'b1;
                    grp_n     = '0;
                    state_n   = SWEEP;
                end
            end
            SWEEP: begin
                if (adv) begin
                    iss   = 1'b1;
                    grp_n = grp + 1'b1;
                    if (grp == GW'(GROUPS - 1))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grp   <= '0;
            px    <= '0;
            py    <= '0;
        end else begin
            state <= state_n;
            grp   <= grp_n;
            if (pix_rd_en) begin
                px <= pix_x;
                py <= pix_y;
            end
        end
    end

    hough_trig_rom #(
        .THETAS    (THETAS),
        .LANES     (LANES),
        .TRIG_FRAC (TRIG_FRAC),
        .TW        (TW),
        .GW        (GW)
    ) u_rom (
        .clock (clock),
        .reset (reset),
        .en    (adv),
        .grp   (grp),
        .cos_q (cos_q),
        .sin_q (sin_q)
    );

    // The pixel rides along so a new pop cannot disturb groups in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_theta <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (adv) begin
            s1_valid <= iss;
            s1_last  <= (grp == GW'(GROUPS - 1));
            s1_theta <= THETA_BITS'(int'(grp) * LANES);
            s1_x     <= px;
            s1_y     <= py;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_theta <= '0;
            for (int k = 0; k < LANES; k++) begin
                s2_xc[k] <= '0;
                s2_ys[k] <= '0;
            end
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_theta <= s1_theta;
            for (int k = 0; k < LANES; k++) begin
                s2_xc[k] <= PW'($signed({1'b0, s1_x})) * PW'($signed(cos_q[k*TW +: TW]));
                s2_ys[k] <= PW'($signed({1'b0, s1_y})) * PW'($signed(sin_q[k*TW +: TW]));
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] bin;
        logic                 in_rng;
        assign sum    = SW'(s2_xc[k]) + SW'(s2_ys[k]);
        assign bin    = (sum >>> SH) + SW'(RHOS / 2);
        assign in_rng = !bin[SW-1] && (bin <= SW'(RHOS - 1));
`ifdef HOUGH_RHO_CLAMP_EN
        assign d_n[k*RHO_BITS +: RHO_BITS] = in_rng ? RHO_BITS'(bin) :
                                             (bin[SW-1] ? '0 : RHO_BITS'(RHOS - 1));
        assign v_n[k] = 1'b1;
`else
        assign d_n[k*RHO_BITS +: RHO_BITS] = in_rng ? RHO_BITS'(bin) : '0;
        assign v_n[k] = in_rng;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_valid  <= 1'b0;
            rho_dout  <= '0;
            rho_valid <= '0;
            rho_theta <= '0;
            rho_last  <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                rho_dout  <= d_n;
                rho_valid <= v_n;
                rho_theta <= s2_theta;
                rho_last  <= s2_last;
            end
        end
    end

endmodule
